// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bits needed to hold values 0..v-1; the counter width is clog2(N+1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned D = 4
) (
  input  logic [D-1:0] i_r,
  input  logic         i_q_msb,
  input  logic [D-1:0] i_v,
  output logic [D-1:0] o_r_next,
  output logic         o_q_bit
);

  logic [D:0]   w_t;
  logic [D-1:0] w_diff;

  // Partial remainder is always < V, so it is carried in D bits; the trial
  // value T needs D+1 bits, and T-V (when taken) is < V so D bits suffice.
  always_comb begin
    w_t      = {i_r, i_q_msb};
    w_diff   = w_t[D-1:0] - i_v;
    o_q_bit  = (w_t >= {1'b0, i_v});
    o_r_next = o_q_bit ? w_diff : w_t[D-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, registered results.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = clog2(N + 1);

  state_t         r_state;
  logic [N-1:0]   r_q;
  logic [D-1:0]   r_v;
  logic [D-1:0]   r_r;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quotient;
  logic [D-1:0]   r_remainder;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;

  logic [D-1:0]   w_r_next;
  logic           w_q_bit;
  logic [N-1:0]   w_q_next;

  div_step #(.D(D)) u_step (
    .i_r      (r_r),
    .i_q_msb  (r_q[N-1]),
    .i_v      (r_v),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  assign w_q_next = {r_q[N-2:0], w_q_bit};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_v         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_q     <= dividend;
              r_v     <= divisor;
              r_r     <= '0;
              r_cnt   <= CW'(N);
              r_busy  <= 1'b1;
              r_dbz   <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector, corner-sequence and exhaustive-sweep bench for seq_divider (N=8, D=4).
module tb_seq_divider;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.N(8), .D(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // lat = edges after the accepting edge at which done is first seen high.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output int lat, output int busy_cnt, output bit to);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    to       = 1'b0;
    while (!done) begin
      if (busy) busy_cnt++;
      if (lat >= 20) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int  lat, bcnt, k, dcount;
  bit  to;

  initial begin
    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
    vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
    vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
    vecs[3] = '{8'd100, 4'd0,  8'hFF,  4'd0, 1'b1};
    vecs[4] = '{8'd50,  4'd6,  8'd8,   4'd2, 1'b0};
    vecs[5] = '{8'd0,   4'd1,  8'd0,   4'd0, 1'b0};
    vecs[6] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
    vecs[7] = '{8'd17,  4'd15, 8'd1,   4'd2, 1'b0};
    vecs[8] = '{8'd128, 4'd3,  8'd42,  4'd2, 1'b0};
    vecs[9] = '{8'd14,  4'd0,  8'hFF,  4'd0, 1'b1};

    resetn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", div_by_zero, 0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, bcnt, to);
      chk($sformatf("vec%0d timeout", i), to, 0);
      chk($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d dbz", i), div_by_zero, vecs[i].z);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].z ? 0 : 8);
      chk($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].z ? 0 : 8);
      @(posedge clk); #1;
      chk($sformatf("vec%0d done one cycle", i), done, 0);
      chk($sformatf("vec%0d quotient held", i), quotient, vecs[i].q);
    end

    // Start pulse mid-run is ignored; start held high is taken in the done cycle.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 2) begin @(posedge clk); #1; k++; end
    @(negedge clk);
    dividend = 8'd9; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    k++;
    start = 1'b0;
    chk("ignore busy", busy, 1);
    while (!done && k < 20) begin
      if (k == 6) begin
        dividend = 8'd50; divisor = 4'd6; start = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    chk("ignore latency", k, 8);
    chk("ignore quotient", quotient, 28);
    chk("ignore remainder", remainder, 4);
    chk("hold busy in done cycle", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold accepted busy", busy, 1);
    chk("hold done cleared", done, 0);
    chk("hold quotient kept", quotient, 28);
    chk("hold remainder kept", remainder, 4);
    k = 0;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    chk("hold latency", k, 8);
    chk("hold quotient", quotient, 8);
    chk("hold remainder", remainder, 2);

    // Reset in the middle of an operation discards it without a done pulse.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midreset quotient", quotient, 0);
    chk("midreset remainder", remainder, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset dbz", div_by_zero, 0);
    @(negedge clk);
    resetn = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("midreset no done", dcount, 0);
    run_op(8'd50, 4'd6, lat, bcnt, to);
    chk("after reset timeout", to, 0);
    chk("after reset quotient", quotient, 8);
    chk("after reset remainder", remainder, 2);

    // Exhaustive sweep against the division identity.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), lat, bcnt, to);
        chk($sformatf("sweep %0d/%0d timeout", a, b), to, 0);
        if (b == 0) begin
          chk($sformatf("sweep %0d/0 quotient", a), quotient, 255);
          chk($sformatf("sweep %0d/0 remainder", a), remainder, 0);
          chk($sformatf("sweep %0d/0 dbz", a), div_by_zero, 1);
          chk($sformatf("sweep %0d/0 latency", a), lat, 0);
        end else begin
          chk($sformatf("sweep %0d/%0d identity", a, b),
              int'(quotient) * b + int'(remainder), a);
          chk($sformatf("sweep %0d/%0d rem<div", a, b), int'(remainder < 4'(b)), 1);
          chk($sformatf("sweep %0d/%0d dbz", a, b), div_by_zero, 0);
          chk($sformatf("sweep %0d/%0d latency", a, b), lat, 8);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
